mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle MIPS control unit that sits directly downstream of the instruction-fetch stage. It consumes the fetched instruction word's opcode and funct fields and sequences each instruction through the IF/ID/EX/MEM/WB states. It drives the PC write strobe and holds Branch/Jump stable, so the fetch stage's next-PC mux resolves once per instruction. It also drives the register-file, ALU and data-memory controls, and keeps a retired-instruction count.

## Interface

- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- Op  in  6  INST[31:26] from fetch stage.
- Funct  in  6  INST[5:0] from fetch stage.
- PCWr  out  1  PC write enable, one cycle per instruction.
- IRWr  out  1  instruction-register load strobe (high in IF).
- RegDst  out  1  1 = rd, 0 = rt as write register.
- ALUSrc  out  1  1 = sign-extended imm16, 0 = rt.
- MemtoReg  out  1  1 = write-back from memory.
- RegWr  out  1  register-file write strobe.
- MemRd  out  1  data-memory read strobe.
- MemWr  out  1  data-memory write strobe.
- Branch  out  1  conditional-branch select, ANDed with Zero by fetch stage.
- Jump  out  1  unconditional-jump select.
- ALUCtrl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- State  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- Illegal  out  1  sticky unsupported-instruction flag.
- InstCnt  out  32  retired-instruction count.

## Operation

- Internal IR (Op, Funct, 12 bits) is loaded in IF. All decoding from ID onward uses the latched IR, never the live inputs.
- Supported opcodes:
  - R-type 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
  - Any other opcode/funct is illegal.
- State transitions:
  - IF: IRWr=1; next ID.
  - ID, j: PCWr=1; next IF.
  - ID, illegal: PCWr=1 (Branch=Jump=0, so PC+4); Illegal set; next IF.
  - ID, all other opcodes: next EX.
  - EX, beq: PCWr=1; next IF. Branch=1, so the fetch stage picks the target when Zero=1.
  - EX, R-type/addi: next WB.
  - EX, lw/sw: next MEM.
  - MEM, lw: MemRd=1; next WB.
  - MEM, sw: MemWr=1, PCWr=1; next IF.
  - WB (R-type/addi/lw): RegWr=1, PCWr=1; next IF.
- Level controls (RegDst, ALUSrc, MemtoReg, Branch, Jump, ALUCtrl):
  - Decoded from IR and held constant from ID through the instruction's last state.
  - Forced to 0 in IF.
- Decode values:
  - RegDst=1 for R-type only.
  - ALUSrc=1 for lw, sw and addi.
  - MemtoReg=1 for lw only.
  - ALUCtrl=010 for lw, sw and addi; 110 for beq; from funct for R-type.
  - ALUCtrl=000 for j and illegal.
- Strobes (PCWr, IRWr, RegWr, MemRd, MemWr) are high only in the states listed above.
- InstCnt increments by 1 on every clock edge where PCWr=1, including illegal instructions. Wraps 0xFFFFFFFF -> 0.
- Illegal stays set until RST.
- Unused state encodings 5-7 return to IF on the next edge with all strobes low.

## Timing

- Moore machine: all outputs are combinational from registered State/IR only. There is no input-to-output combinational path, and Zero is not an input.
- Cycles per instruction: j 2, beq 3, R-type/addi 4, sw 4, lw 5, illegal 2.
- The PC update occurs at the rising edge that ends the instruction's last state. The next IF sees the new PC's instruction.
- Reset values: State=IF, IR=0, Illegal=0, InstCnt=0. With State=IF, IRWr=1 and every other output is 0.
- RST asserted mid-instruction forces IF immediately (asynchronously), with no further PCWr, RegWr or MemWr for the aborted instruction.
- First instruction after RST release: IR loads at the first rising edge.

## Test plan

- Reset → State=0, IRWr=1, PCWr=RegWr=MemWr=MemRd=0, InstCnt=0, Illegal=0.
- add (Op 0x00, Funct 0x20) → states 0,1,2,4,0.
  - RegDst=1, ALUCtrl=010 from ID through WB.
  - RegWr=PCWr=1 only in WB.
  - InstCnt=1 after 4 cycles.
- lw 0x23 then sw 0x2B:
  - lw takes 5 cycles: MemRd=1 in MEM, RegWr=MemtoReg=1 in WB.
  - sw takes 4 cycles: MemWr=PCWr=1 in MEM, RegWr never 1.
  - InstCnt=2.
- beq 0x04 → 3 cycles; Branch=1, ALUCtrl=110 in ID and EX; PCWr=1 only in EX. Change Op in EX: outputs unchanged (IR latched).
- j 0x02 → 2 cycles, Jump=1 and PCWr=1 in ID. Opcode 0x3F → 2 cycles, PCWr=1 in ID, Illegal=1 and stays 1 through a following add.
- Assert RST during MEM of sw → State=0 within the same cycle, MemWr drops immediately, InstCnt=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS control unit.
//
// Sequences each fetched instruction through IF/ID/EX/MEM/WB. It latches the
// opcode and funct fields into an internal IR during IF and decodes only from
// that IR afterwards. Every output is a function of registered state (Moore),
// so nothing here forms a combinational path from Op/Funct to an output.
//
// Ports:
//   CLK      in   1   system clock, rising edge
//   RST      in   1   asynchronous active-high reset
//   Op       in   6   INST[31:26] from the fetch stage
//   Funct    in   6   INST[5:0] from the fetch stage
//   PCWr     out  1   PC write enable, one cycle per instruction
//   IRWr     out  1   IR load strobe (IF only)
//   RegDst   out  1   1 = rd, 0 = rt as the write register
//   ALUSrc   out  1   1 = sign-extended imm16, 0 = rt
//   MemtoReg out  1   1 = write back from data memory
//   RegWr    out  1   register-file write strobe
//   MemRd    out  1   data-memory read strobe
//   MemWr    out  1   data-memory write strobe
//   Branch   out  1   conditional-branch select (ANDed with Zero downstream)
//   Jump     out  1   unconditional-jump select
//   ALUCtrl  out  3   000 and, 001 or, 010 add, 110 sub, 111 slt
//   State    out  3   IF=0, ID=1, EX=2, MEM=3, WB=4
//   Illegal  out  1   sticky unsupported-instruction flag
//   InstCnt  out  32  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module mc_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWr,
    output logic        MemRd,
    output logic        MemWr,
    output logic        Branch,
    output logic        Jump,
    output logic [2:0]  ALUCtrl,
    output logic [2:0]  State,
    output logic        Illegal,
    output logic [31:0] InstCnt
);

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        IC_R, IC_LW, IC_SW, IC_BEQ, IC_J, IC_ADDI, IC_ILL
    } iclass_e;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [5:0]  funct_q, funct_d;
    logic        illegal_q, illegal_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;

    iclass_e     iclass;
    logic [2:0]  r_alu;

    // Instruction class decoded from the latched IR only.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        iclass = IC_ILL;
        r_alu  = 3'b000;
        case (op_q)
            6'h00: begin
                case (funct_q)
                    6'h20: begin iclass = IC_R; r_alu = 3'b010; end
                    6'h22: begin iclass = IC_R; r_alu = 3'b110; end
                    6'h24: begin iclass = IC_R; r_alu = 3'b000; end
                    6'h25: begin iclass = IC_R; r_alu = 3'b001; end
                    6'h2A: begin iclass = IC_R; r_alu = 3'b111; end
                    default: iclass = IC_ILL;
                endcase
            end
            6'h23:   iclass = IC_LW;
            6'h2B:   iclass = IC_SW;
            6'h04:   iclass = IC_BEQ;
            6'h02:   iclass = IC_J;
            6'h08:   iclass = IC_ADDI;
            default: iclass = IC_ILL;
        endcase
    end

    logic pc_wr, ir_wr, reg_wr, mem_rd, mem_wr;
    logic level_en;

    // Next-state, strobes and IR/flag/counter updates.
    always_comb begin
        state_d   = ST_IF;
        op_d      = op_q;
        funct_d   = funct_q;
        illegal_d = illegal_q;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        level_en  = 1'b0;

        case (state_q)
            ST_IF: begin
                ir_wr   = 1'b1;
                op_d    = Op;
                funct_d = Funct;
                state_d = ST_ID;
            end
            ST_ID: begin
                level_en = 1'b1;
                if (iclass == IC_J || iclass == IC_ILL) begin
                    // Illegal instructions retire as a plain PC+4 step.
                    pc_wr     = 1'b1;
                    illegal_d = illegal_q | (iclass == IC_ILL);
                    state_d   = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                level_en = 1'b1;
                case (iclass)
                    IC_BEQ: begin
                        pc_wr   = 1'b1;
                        state_d = ST_IF;
                    end
                    IC_LW, IC_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                level_en = 1'b1;
                if (iclass == IC_LW) begin
                    mem_rd  = 1'b1;
                    state_d = ST_WB;
                end else if (iclass == IC_SW) begin
                    mem_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_WB: begin
                level_en = 1'b1;
                reg_wr   = 1'b1;
                pc_wr    = 1'b1;
                state_d  = ST_IF;
            end
            // Unused encodings fall back to IF with every strobe low.
            default: state_d = ST_IF;
        endcase

        inst_cnt_d = inst_cnt_q + {31'd0, pc_wr};
    end

    // Level controls: decoded from IR, held from ID to the last state, 0 in IF.
    always_comb begin
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        ALUCtrl  = 3'b000;
        if (level_en) begin
            RegDst   = (iclass == IC_R);
            ALUSrc   = (iclass == IC_LW) || (iclass == IC_SW) || (iclass == IC_ADDI);
            MemtoReg = (iclass == IC_LW);
            Branch   = (iclass == IC_BEQ);
            Jump     = (iclass == IC_J);
            case (iclass)
                IC_R:                  ALUCtrl = r_alu;
                IC_LW, IC_SW, IC_ADDI: ALUCtrl = 3'b010;
                IC_BEQ:                ALUCtrl = 3'b110;
                default:               ALUCtrl = 3'b000;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IF;
            op_q       <= 6'd0;
            funct_q    <= 6'd0;
            illegal_q  <= 1'b0;
            inst_cnt_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            op_q       <= op_d;
            funct_q    <= funct_d;
            illegal_q  <= illegal_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign PCWr    = pc_wr;
    assign IRWr    = ir_wr;
    assign RegWr   = reg_wr;
    assign MemRd   = mem_rd;
    assign MemWr   = mem_wr;
    assign State   = state_q;
    assign Illegal = illegal_q;
    assign InstCnt = inst_cnt_q;

endmodule
